// File: rtl/spi_pkt_pkg.sv
// Sizing helpers shared by the SPI packet disassembler and its chunk mux.
// Chunk count and index width are derived in one place so every user agrees on them.
package spi_pkt_pkg;

  // Number of NBITS_OUT chunks needed to cover NBITS_IN bits (top chunk zero-padded)
  function automatic int num_chunks(input int nbits_in, input int nbits_out);
    return (nbits_in + nbits_out - 1) / nbits_out;
  endfunction

  // Index width for n chunks; never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the zero-padded capture register
  function automatic int pad_w(input int nbits_in, input int nbits_out);
    return num_chunks(nbits_in, nbits_out) * nbits_out;
  endfunction

endpackage

// File: rtl/spi_pkt_chunk_sel.sv
// Combinational NUM_CHUNKS:1 chunk mux; output forced to zero when en is low.
// No state, zero latency; backpressure is handled entirely by the caller.
module spi_pkt_chunk_sel #(
  parameter int NBITS_OUT  = 8,
  parameter int NUM_CHUNKS = 4,
  parameter int SEL_W      = 2
) (
  input  logic [NUM_CHUNKS*NBITS_OUT-1:0] data,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            en,
  output logic [NBITS_OUT-1:0]            msg
);

  always_comb begin
    msg = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (en && (sel == SEL_W'(k))) begin
        msg = data[k*NBITS_OUT +: NBITS_OUT];
      end
    end
  end

endmodule

// File: rtl/spi_pkt_disassembler_pipe.sv
// Wide request packet -> narrow chunk stream, 1-cycle accept-to-first-chunk latency, zero-bubble reload.
// req_rdy follows resp_rdy combinationally on the last chunk; SPI_PKT_DISASM_VARLEN_EN adds a req_len port.
module spi_pkt_disassembler_pipe
  import spi_pkt_pkg::*;
#(
  parameter int  NBITS_IN   = 32,
  parameter int  NBITS_OUT  = 8,
  parameter bit  MSB_FIRST  = 1'b1,
  localparam int NUM_CHUNKS = num_chunks(NBITS_IN, NBITS_OUT),
  localparam int CNT_W      = cnt_w(NUM_CHUNKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [NBITS_IN-1:0]  req_msg,
`ifdef SPI_PKT_DISASM_VARLEN_EN
  input  logic [CNT_W-1:0]     req_len,
`endif
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [NBITS_OUT-1:0] resp_msg,
  output logic                 resp_last
);

  localparam int               PAD_W    = pad_w(NBITS_IN, NBITS_OUT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

  typedef logic [NBITS_OUT-1:0] chunk_t;

  typedef struct packed {
    logic             vld;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] end_idx;
  } seq_t;

  seq_t             seq_q, seq_d;
  logic [PAD_W-1:0] data_q, data_d;
  logic [PAD_W-1:0] req_pad;
  logic [CNT_W-1:0] len;
  logic             is_last;
  logic             accept;
  logic             xfer;
  chunk_t           cur_chunk;

  always_comb begin
    req_pad = '0;
    req_pad[NBITS_IN-1:0] = req_msg;
  end

`ifdef SPI_PKT_DISASM_VARLEN_EN
  assign len = (req_len > LAST_IDX) ? LAST_IDX : req_len;
`else
  assign len = LAST_IDX;
`endif

  // Outputs are masked during reset so stale state never leaks out
  assign is_last   = seq_q.vld & (seq_q.idx == seq_q.end_idx);
  assign resp_val  = seq_q.vld & ~reset;
  assign resp_last = is_last & ~reset;
  assign req_rdy   = ~reset & (~seq_q.vld | (resp_rdy & is_last));
  assign accept    = req_val & req_rdy;
  assign xfer      = resp_val & resp_rdy;

  // An accept can only coincide with the final transfer, so it simply overrides the step
  always_comb begin
    seq_d  = seq_q;
    data_d = data_q;
    if (accept) begin
      data_d        = req_pad;
      seq_d.vld     = 1'b1;
      seq_d.idx     = MSB_FIRST ? len : '0;
      seq_d.end_idx = MSB_FIRST ? '0 : len;
    end else if (xfer) begin
      if (is_last) begin
        seq_d.vld = 1'b0;
      end else if (MSB_FIRST) begin
        seq_d.idx = seq_q.idx - CNT_W'(1);
      end else begin
        seq_d.idx = seq_q.idx + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q  <= '0;
      data_q <= '0;
    end else begin
      seq_q  <= seq_d;
      data_q <= data_d;
    end
  end

  spi_pkt_chunk_sel #(
    .NBITS_OUT  (NBITS_OUT),
    .NUM_CHUNKS (NUM_CHUNKS),
    .SEL_W      (CNT_W)
  ) u_chunk_sel (
    .data (data_q),
    .sel  (seq_q.idx),
    .en   (resp_val),
    .msg  (cur_chunk)
  );

  assign resp_msg = cur_chunk;

endmodule

// File: tb/tb_spi_pkt_disassembler_pipe.sv
// Scoreboard bench: 32->8 MSB-first instance plus a 12->8 LSB-first instance.
// Define SPI_PKT_DISASM_VARLEN_EN at compile time to exercise the req_len port.
module tb_spi_pkt_disassembler_pipe;

  typedef struct packed {
    logic [7:0] msg;
    logic       last;
  } exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  len;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_val = 1'b0;
  logic        req_rdy;
  logic [31:0] req_msg = '0;
`ifdef SPI_PKT_DISASM_VARLEN_EN
  logic [1:0]  req_len = '0;
`endif
  logic        resp_val;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp_msg;
  logic        resp_last;

  logic        b_req_val = 1'b0;
  logic        b_req_rdy;
  logic [11:0] b_req_msg = '0;
`ifdef SPI_PKT_DISASM_VARLEN_EN
  logic        b_req_len = 1'b1;
`endif
  logic        b_resp_val;
  logic        b_resp_rdy = 1'b0;
  logic [7:0]  b_resp_msg;
  logic        b_resp_last;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t sb_q[$];
  exp_t b_sb_q[$];
  pkt_t pkt_q[$];
  int   acc_cyc[$];
  int   xfer_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_pkt_disassembler_pipe #(.NBITS_IN(32), .NBITS_OUT(8), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_msg   (req_msg),
`ifdef SPI_PKT_DISASM_VARLEN_EN
    .req_len   (req_len),
`endif
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_msg  (resp_msg),
    .resp_last (resp_last)
  );

  spi_pkt_disassembler_pipe #(.NBITS_IN(12), .NBITS_OUT(8), .MSB_FIRST(1'b0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_val   (b_req_val),
    .req_rdy   (b_req_rdy),
    .req_msg   (b_req_msg),
`ifdef SPI_PKT_DISASM_VARLEN_EN
    .req_len   (b_req_len),
`endif
    .resp_val  (b_resp_val),
    .resp_rdy  (b_resp_rdy),
    .resp_msg  (b_resp_msg),
    .resp_last (b_resp_last)
  );

  // Expected chunks for the 32->8 MSB-first instance; len is chunks-1 before clamping
  function automatic void push_expected(input logic [31:0] d, input int len_req);
    int len;
`ifdef SPI_PKT_DISASM_VARLEN_EN
    len = (len_req % 4 > 3) ? 3 : len_req % 4;
`else
    len = 3;
    if (len_req < 0) len = 3;
`endif
    for (int i = 0; i <= len; i++) begin
      int k;
      exp_t e;
      k = len - i;
      e.msg  = 8'((d >> (8 * k)) & 32'hFF);
      e.last = (i == len);
      sb_q.push_back(e);
    end
  endfunction

  task automatic run_stream(input int rdy_pct, input int max_cyc);
    logic       stalled;
    logic [7:0] held;
    exp_t       e;
    logic       exp_rdy;
    stalled = 1'b0;
    held    = '0;
    acc_cyc.delete();
    xfer_cyc.delete();
    for (int c = 0; c < max_cyc && (pkt_q.size() > 0 || sb_q.size() > 0); c++) begin
      @(negedge clk);
      req_val  = (pkt_q.size() > 0);
      req_msg  = req_val ? pkt_q[0].data : 32'h0;
`ifdef SPI_PKT_DISASM_VARLEN_EN
      req_len  = req_val ? pkt_q[0].len[1:0] : 2'd0;
`endif
      resp_rdy = ($urandom_range(0, 99) < rdy_pct);
      #1;
      n_checks++;
      if (resp_val !== (sb_q.size() > 0)) begin
        n_fail++;
        $display("FAIL stream_val: resp_val=%b expected %b (cyc %0d)", resp_val, sb_q.size() > 0, cyc);
      end
      exp_rdy = (sb_q.size() == 0) || (resp_rdy && sb_q.size() == 1);
      n_checks++;
      if (req_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL stream_req_rdy: req_rdy=%b expected %b (cyc %0d)", req_rdy, exp_rdy, cyc);
      end
      if (stalled) begin
        n_checks++;
        if (resp_val !== 1'b1 || resp_msg !== held) begin
          n_fail++;
          $display("FAIL stall_hold: val=%b msg=%h expected val=1 msg=%h", resp_val, resp_msg, held);
        end
      end
      if (resp_val !== 1'b1) begin
        n_checks++;
        if (resp_msg !== 8'h00 || resp_last !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_zero: msg=%h last=%b expected 00/0", resp_msg, resp_last);
        end
      end else if (resp_rdy) begin
        xfer_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_chunk: msg=%h with empty scoreboard", resp_msg);
        end else begin
          e = sb_q.pop_front();
          n_checks++;
          if (resp_msg !== e.msg || resp_last !== e.last) begin
            n_fail++;
            $display("FAIL chunk: msg=%h last=%b expected msg=%h last=%b", resp_msg, resp_last, e.msg, e.last);
          end
        end
      end
      stalled = resp_val && !resp_rdy;
      held    = resp_msg;
      if (req_val && req_rdy) begin
        acc_cyc.push_back(cyc);
        push_expected(pkt_q[0].data, int'(pkt_q[0].len));
        void'(pkt_q.pop_front());
      end
    end
    n_checks++;
    if (pkt_q.size() != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_timeout: %0d packets, %0d chunks left, expected 0/0", pkt_q.size(), sb_q.size());
      pkt_q.delete();
      sb_q.delete();
    end
    @(negedge clk);
    req_val  = 1'b0;
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    req_val = 1'b1;
    req_msg = 32'hFFFF_FFFF;
    resp_rdy = 1'b1;
    b_req_val = 1'b1;
    b_resp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({resp_val, resp_last, resp_msg, req_rdy} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_a: val=%b last=%b msg=%h rdy=%b expected all 0", resp_val, resp_last, resp_msg, req_rdy);
    end
    n_checks++;
    if ({b_resp_val, b_resp_last, b_resp_msg, b_req_rdy} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_b: val=%b last=%b msg=%h rdy=%b expected all 0", b_resp_val, b_resp_last, b_resp_msg, b_req_rdy);
    end
    @(negedge clk);
    reset = 1'b0;
    req_val = 1'b0;
    b_req_val = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({resp_val, resp_last, resp_msg, req_rdy} !== 11'h1) begin
      n_fail++;
      $display("FAIL post_reset: val=%b last=%b msg=%h rdy=%b expected 0/0/00/1", resp_val, resp_last, resp_msg, req_rdy);
    end
    resp_rdy = 1'b0;
    b_resp_rdy = 1'b0;
  endtask

  task automatic test_single();
    pkt_q.push_back('{data: 32'hAABBCCDD, len: 3'd3});
    run_stream(100, 50);
    n_checks++;
    if (xfer_cyc.size() != 4 || xfer_cyc[3] - xfer_cyc[0] != 3) begin
      n_fail++;
      $display("FAIL single_span: beats=%0d span=%0d expected 4/3", xfer_cyc.size(), xfer_cyc[3] - xfer_cyc[0]);
    end
    n_checks++;
    if (xfer_cyc[0] != acc_cyc[0] + 1) begin
      n_fail++;
      $display("FAIL single_latency: first chunk cyc %0d expected %0d", xfer_cyc[0], acc_cyc[0] + 1);
    end
  endtask

  task automatic test_back_to_back();
    pkt_q.push_back('{data: 32'h0102A0B0, len: 3'd3});
    pkt_q.push_back('{data: 32'hC3D4E5F6, len: 3'd3});
    run_stream(100, 50);
    n_checks++;
    if (xfer_cyc.size() != 8 || xfer_cyc[7] - xfer_cyc[0] != 7) begin
      n_fail++;
      $display("FAIL b2b_span: beats=%0d span=%0d expected 8/7", xfer_cyc.size(), xfer_cyc[7] - xfer_cyc[0]);
    end
    n_checks++;
    if (acc_cyc.size() != 2 || acc_cyc[1] != xfer_cyc[3]) begin
      n_fail++;
      $display("FAIL b2b_accept: second accept cyc %0d expected %0d", acc_cyc[1], xfer_cyc[3]);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) pkt_q.push_back('{data: $urandom, len: 3'd3});
    run_stream(45, 400);
  endtask

  task automatic test_lsb_pad();
    logic [15:0] pad;
    exp_t        e;
    pad = 16'h0ABC;
    @(negedge clk);
    b_req_val  = 1'b1;
    b_req_msg  = 12'hABC;
    b_resp_rdy = 1'b1;
    #1;
    n_checks++;
    if (b_req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_req_rdy: req_rdy=%b expected 1", b_req_rdy);
    end
    b_sb_q.push_back('{msg: pad[7:0], last: 1'b0});
    b_sb_q.push_back('{msg: pad[15:8], last: 1'b1});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      b_req_val = 1'b0;
      #1;
      if (b_resp_val === 1'b1) begin
        n_checks++;
        if (b_sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL lsb_extra: msg=%h with empty scoreboard", b_resp_msg);
        end else begin
          e = b_sb_q.pop_front();
          if (b_resp_msg !== e.msg || b_resp_last !== e.last) begin
            n_fail++;
            $display("FAIL lsb_chunk: msg=%h last=%b expected %h/%b", b_resp_msg, b_resp_last, e.msg, e.last);
          end
        end
      end
    end
    n_checks++;
    if (b_sb_q.size() != 0 || b_resp_msg !== 8'h00) begin
      n_fail++;
      $display("FAIL lsb_drain: left=%0d msg=%h expected 0/00", b_sb_q.size(), b_resp_msg);
    end
    b_sb_q.delete();
    b_resp_rdy = 1'b0;
  endtask

`ifdef SPI_PKT_DISASM_VARLEN_EN
  task automatic test_varlen();
    pkt_q.push_back('{data: 32'h11223344, len: 3'd1});
    pkt_q.push_back('{data: 32'h11223344, len: 3'd7});
    run_stream(100, 50);
    n_checks++;
    if (xfer_cyc.size() != 6) begin
      n_fail++;
      $display("FAIL varlen_beats: beats=%0d expected 6", xfer_cyc.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] exp_first [2];
    exp_first[0] = 8'h55;
    exp_first[1] = 8'h66;
    @(negedge clk);
    req_val  = 1'b1;
    req_msg  = 32'h55667788;
`ifdef SPI_PKT_DISASM_VARLEN_EN
    req_len  = 2'd3;
`endif
    resp_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_val = 1'b0;
      #1;
      n_checks++;
      if (resp_val !== 1'b1 || resp_msg !== exp_first[i]) begin
        n_fail++;
        $display("FAIL mid_chunk%0d: val=%b msg=%h expected 1/%h", i, resp_val, resp_msg, exp_first[i]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_val !== 1'b0 || resp_msg !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: val=%b msg=%h expected 0/00", resp_val, resp_msg);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: val=%b expected 0", resp_val);
    end
    pkt_q.push_back('{data: 32'h01020304, len: 3'd3});
    run_stream(100, 50);
    n_checks++;
    if (xfer_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL mid_restart: beats=%0d expected 4", xfer_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lsb_pad();
`ifdef SPI_PKT_DISASM_VARLEN_EN
    test_varlen();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
